adc733_frame_collector: RTL and testbench

Downstream consumer of the 6-channel serial ADC wrapper. Issues the periodic one-cycle capture strobe to the ADC wrapper and collects the per-channel samples it returns into complete frames. Double-buffers frames in ping-pong banks and streams them out over a valid/ready handshake toward the VSI transmit path. Flags incomplete and dropped frames.

---
 rtl/adc733_frame_collector.sv | 174 +++++++++++++++++
 tb/tb_adc733_frame_collector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc733_frame_collector.sv
// adc733_frame_collector: strobes the ADC wrapper, gathers NCH samples per frame into ping-pong banks, streams them over valid/ready.
// Optional duplicate-sample detection is built when ADC733_COLLECT_CHKDUP_EN is defined.
module adc733_frame_collector #(
    parameter int SYNC_DIV = 100000,
    parameter int NCH      = 6,
    parameter int DW       = 16,
    parameter int TIMEOUT  = 4096
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          enable,
    input  logic          err_clr,
    output logic          sync,
    input  logic          adc_op_mode,
    input  logic [DW-1:0] adc_data,
    input  logic          adc_rd_en,
    input  logic [2:0]    adc_channel,
    output logic [DW-1:0] out_data,
    output logic [2:0]    out_ch,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [15:0]   frame_cnt,
    output logic          err_timeout,
    output logic          err_overflow,
    output logic          err_dup
);
    localparam int DVW = $clog2(SYNC_DIV);
    localparam int TOW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE} state_t;

    state_t           state_q, state_d;
    logic [DVW-1:0]   div_q, div_d;
    logic [TOW-1:0]   to_cnt_q, to_cnt_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [2:0]       rd_idx_q, rd_idx_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [DW-1:0]    bank_q [2][NCH];
    logic [DW-1:0]    bank_d [2][NCH];
    logic             sync_q, sync_d, drop_q, drop_d, wr_sel_q, wr_sel_d;
    logic             wr_full_q, wr_full_d, rd_full_q, rd_full_d;
    logic             err_timeout_q, err_timeout_d, err_overflow_q, err_overflow_d;
    logic             tick, mask_full, complete, timeout, ch_ok, wr_en;
    logic             xfer, last_xfer, rd_free, swap_new, hold_new, overflow, swap_pend;
    logic [NCH-1:0]   ch_bit;

    // Frame bookkeeping: a completed frame goes to the read bank if it is free, is parked in
    // the write bank if not, and a frame captured while a frame is already parked is dropped.
    always_comb begin
        tick           = enable && div_q == DVW'(SYNC_DIV - 1);
        div_d          = (!enable || tick) ? '0 : div_q + 1'b1;
        mask_full      = mask_q == '1;
        complete       = state_q == S_CAPTURE && mask_full;
        timeout        = state_q == S_CAPTURE && !mask_full && to_cnt_q == TOW'(TIMEOUT - 1);
        ch_ok          = 32'(adc_channel) < NCH;
        ch_bit         = NCH'(1) << adc_channel;
        wr_en          = state_q == S_CAPTURE && !mask_full && adc_rd_en && ch_ok;
        xfer           = rd_full_q && out_ready;
        last_xfer      = xfer && rd_idx_q == 3'(NCH - 1);
        rd_free        = !rd_full_q || last_xfer;
        swap_new       = complete && !drop_q && rd_free;
        hold_new       = complete && !drop_q && !rd_free;
        overflow       = complete && drop_q;
        swap_pend      = wr_full_q && last_xfer;
        wr_sel_d       = wr_sel_q ^ (swap_new || swap_pend);
        wr_full_d      = hold_new || (wr_full_q && !last_xfer);
        rd_full_d      = swap_new || swap_pend || (rd_full_q && !last_xfer);
        rd_idx_d       = !xfer ? rd_idx_q : last_xfer ? 3'd0 : rd_idx_q + 3'd1;
        frame_cnt_d    = frame_cnt_q + 16'(last_xfer);
        err_timeout_d  = (err_timeout_q && !err_clr) || timeout;
        err_overflow_d = (err_overflow_q && !err_clr) || overflow;
    end

    // Capture FSM: strobe on a divider tick while waiting, collect samples until complete or timed out.
    always_comb begin
        state_d  = state_q;
        sync_d   = 1'b0;
        mask_d   = mask_q;
        to_cnt_d = to_cnt_q;
        drop_d   = drop_q;
        case (state_q)
            S_IDLE: state_d = enable ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (tick && adc_op_mode) begin
                    sync_d   = 1'b1;
                    mask_d   = '0;
                    to_cnt_d = '0;
                    drop_d   = wr_full_q && !last_xfer;
                    state_d  = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                to_cnt_d = to_cnt_q + 1'b1;
                mask_d   = wr_en ? mask_q | ch_bit : mask_q;
                state_d  = (complete || timeout) ? S_WAIT : S_CAPTURE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sample storage; writes are suppressed for a frame that is already doomed to be dropped.
    always_comb begin
        bank_d = bank_q;
        if (wr_en && !drop_q) bank_d[wr_sel_q][adc_channel] = adc_data;
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q        <= S_IDLE;
            div_q          <= '0;
            to_cnt_q       <= '0;
            mask_q         <= '0;
            rd_idx_q       <= '0;
            frame_cnt_q    <= '0;
            sync_q         <= 1'b0;
            drop_q         <= 1'b0;
            wr_sel_q       <= 1'b0;
            wr_full_q      <= 1'b0;
            rd_full_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            div_q          <= div_d;
            to_cnt_q       <= to_cnt_d;
            mask_q         <= mask_d;
            rd_idx_q       <= rd_idx_d;
            frame_cnt_q    <= frame_cnt_d;
            sync_q         <= sync_d;
            drop_q         <= drop_d;
            wr_sel_q       <= wr_sel_d;
            wr_full_q      <= wr_full_d;
            rd_full_q      <= rd_full_d;
            err_timeout_q  <= err_timeout_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    // Bank contents are pure datapath; validity is tracked by the full flags.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

`ifdef ADC733_COLLECT_CHKDUP_EN
    logic err_dup_q, err_dup_d;

    // Flag a sample arriving for a channel already received in this frame.
    always_comb begin
        err_dup_d = (err_dup_q && !err_clr) || (wr_en && |(mask_q & ch_bit));
    end

    // Sticky duplicate flag register.
    always_ff @(posedge clk) begin
        err_dup_q <= !rst_l ? 1'b0 : err_dup_d;
    end

    assign err_dup = err_dup_q;
`else
    assign err_dup = 1'b0;
`endif

    assign sync         = sync_q;
    assign out_valid    = rd_full_q;
    assign out_data     = rd_full_q ? bank_q[~wr_sel_q][rd_idx_q] : '0;
    assign out_ch       = rd_idx_q;
    assign out_last     = rd_full_q && rd_idx_q == 3'(NCH - 1);
    assign frame_cnt    = frame_cnt_q;
    assign err_timeout  = err_timeout_q;
    assign err_overflow = err_overflow_q;
endmodule

// File: tb/tb_adc733_frame_collector.sv
// tb_adc733_frame_collector: directed self-checking bench for adc733_frame_collector (SYNC_DIV=100, NCH=6, TIMEOUT=200).
module tb_adc733_frame_collector;
    logic        clk = 1'b0;
    logic        rst_l, enable, err_clr, adc_op_mode, adc_rd_en, out_ready;
    logic [15:0] adc_data;
    logic [2:0]  adc_channel;
    logic        sync, out_valid, out_last, err_timeout, err_overflow, err_dup;
    logic [15:0] out_data, frame_cnt;
    logic [2:0]  out_ch;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc_no = 0;
    int          s0 = 0;
    int          nsync = 0;
    logic [15:0] exp_w [12];

`ifdef ADC733_COLLECT_CHKDUP_EN
    localparam logic EXP_DUP = 1'b1;
`else
    localparam logic EXP_DUP = 1'b0;
`endif

    adc733_frame_collector #(.SYNC_DIV(100), .NCH(6), .DW(16), .TIMEOUT(200)) dut (
        .clk(clk), .rst_l(rst_l), .enable(enable), .err_clr(err_clr), .sync(sync),
        .adc_op_mode(adc_op_mode), .adc_data(adc_data), .adc_rd_en(adc_rd_en),
        .adc_channel(adc_channel), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_cnt(frame_cnt), .err_timeout(err_timeout), .err_overflow(err_overflow),
        .err_dup(err_dup)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] ch, input logic [15:0] d);
        adc_rd_en   = 1'b1;
        adc_channel = ch;
        adc_data    = d;
        cyc();
        adc_rd_en   = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] base);
        for (int i = 0; i < 6; i++) send(3'(i), base + 16'(i));
    endtask

    task automatic wait_sync(input string tag);
        int n = 0;
        while (sync !== 1'b1 && n < 400) begin
            cyc();
            n++;
        end
        chk(tag, {31'd0, sync}, 32'd1);
        s0 = cyc_no;
    endtask

    task automatic set_exp(input logic [15:0] base, input int off);
        for (int i = 0; i < 6; i++) exp_w[off + i] = base + 16'(i);
    endtask

    task automatic collect(input string tag, input int n);
        int w = 0;
        out_ready = 1'b1;
        while (out_valid !== 1'b1 && w < 20) begin
            cyc();
            w++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_ch"}, {29'd0, out_ch}, 32'(i % 6));
            chk({tag, "_data"}, {16'd0, out_data}, {16'd0, exp_w[i]});
            chk({tag, "_last"}, {31'd0, out_last}, {31'd0, (i % 6) == 5});
            cyc();
        end
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        cyc();
        cyc();
        rst_l = 1'b1;
    endtask

    initial begin
        rst_l = 1'b0; enable = 1'b0; err_clr = 1'b0; adc_op_mode = 1'b1;
        adc_rd_en = 1'b0; adc_channel = 3'd0; adc_data = 16'd0; out_ready = 1'b1;
        repeat (3) cyc();
        chk("rst_sync", {31'd0, sync}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_data", {16'd0, out_data}, 32'd0);
        chk("rst_ch", {29'd0, out_ch}, 32'd0);
        chk("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_errs", {29'd0, err_timeout, err_overflow, err_dup}, 32'd0);
        rst_l = 1'b1;
        enable = 1'b1;

        // Basic in-order frame, latency and strobe period
        wait_sync("sync1");
        send(3'd0, 16'h1000);
        chk("sync_width", {31'd0, sync}, 32'd0);
        for (int i = 1; i < 6; i++) send(3'(i), 16'h1000 + 16'(i));
        chk("lat_n1", {31'd0, out_valid}, 32'd0);
        cyc();
        chk("lat_n2", {31'd0, out_valid}, 32'd1);
        set_exp(16'h1000, 0);
        collect("f1", 6);
        chk("f1_empty", {31'd0, out_valid}, 32'd0);
        chk("f1_fcnt", {16'd0, frame_cnt}, 32'd1);
        begin
            int p;
            p = s0;
            wait_sync("sync2");
            chk("sync_period", 32'(s0 - p), 32'd100);
        end

        // Out-of-order delivery
        send(3'd5, 16'h2005); send(3'd3, 16'h2003); send(3'd0, 16'h2000);
        send(3'd1, 16'h2001); send(3'd4, 16'h2004); send(3'd2, 16'h2002);
        set_exp(16'h2000, 0);
        collect("f2", 6);
        chk("f2_fcnt", {16'd0, frame_cnt}, 32'd2);

        // Back-pressure: one frame held, one parked, third dropped
        do_reset();
        out_ready = 1'b0;
        wait_sync("ov_s1");
        send_frame(16'h3000);
        wait_sync("ov_s2");
        send_frame(16'h4000);
        cyc(); cyc();
        chk("ov_no_err", {31'd0, err_overflow}, 32'd0);
        wait_sync("ov_s3");
        send_frame(16'h5000);
        cyc(); cyc();
        chk("ov_err", {31'd0, err_overflow}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_ch", {29'd0, out_ch}, 32'd0);
            chk("hold_data", {16'd0, out_data}, 32'h3000);
            cyc();
        end
        set_exp(16'h3000, 0);
        set_exp(16'h4000, 6);
        collect("ov", 12);
        chk("ov_empty", {31'd0, out_valid}, 32'd0);
        chk("ov_fcnt", {16'd0, frame_cnt}, 32'd2);

        // Timeout on a partial frame, then recovery
        do_reset();
        wait_sync("to_s");
        for (int i = 0; i < 5; i++) send(3'(i), 16'h6100 + 16'(i));
        while (cyc_no < s0 + 199) cyc();
        chk("to_early", {31'd0, err_timeout}, 32'd0);
        cyc();
        chk("to_set", {31'd0, err_timeout}, 32'd1);
        chk("to_nodata", {31'd0, out_valid}, 32'd0);
        begin
            int p;
            p = s0;
            wait_sync("to_s2");
            chk("to_skip_tick", 32'(s0 - p), 32'd300);
        end
        send_frame(16'h6000);
        set_exp(16'h6000, 0);
        collect("to_f", 6);
        chk("to_fcnt", {16'd0, frame_cnt}, 32'd1);

        // Duplicate channel sample, then clear of sticky flags
        wait_sync("dup_s");
        send(3'd0, 16'h7000); send(3'd1, 16'h7001); send(3'd2, 16'hAAAA);
        send(3'd2, 16'hBBBB); send(3'd3, 16'h7003); send(3'd4, 16'h7004);
        send(3'd5, 16'h7005);
        set_exp(16'h7000, 0);
        exp_w[2] = 16'hBBBB;
        collect("dup", 6);
        chk("dup_flag", {31'd0, err_dup}, {31'd0, EXP_DUP});
        chk("pre_clr_to", {31'd0, err_timeout}, 32'd1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("clr_errs", {29'd0, err_timeout, err_overflow, err_dup}, 32'd0);

        // Reset in the middle of a frame
        wait_sync("mf_s");
        for (int i = 0; i < 3; i++) send(3'(i), 16'h8000 + 16'(i));
        rst_l = 1'b0;
        cyc();
        chk("mf_sync", {31'd0, sync}, 32'd0);
        chk("mf_valid", {31'd0, out_valid}, 32'd0);
        chk("mf_fcnt", {16'd0, frame_cnt}, 32'd0);
        rst_l = 1'b1;
        wait_sync("mf_s2");
        for (int i = 3; i < 6; i++) send(3'(i), 16'h8000 + 16'(i));
        repeat (5) cyc();
        chk("mf_nopartial", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a stream
        do_reset();
        out_ready = 1'b0;
        wait_sync("ms_s");
        send_frame(16'h9000);
        cyc(); cyc();
        out_ready = 1'b1;
        cyc(); cyc();
        out_ready = 1'b0;
        chk("ms_pre_ch", {29'd0, out_ch}, 32'd2);
        rst_l = 1'b0;
        cyc();
        chk("ms_valid", {31'd0, out_valid}, 32'd0);
        chk("ms_data", {16'd0, out_data}, 32'd0);
        chk("ms_ch", {29'd0, out_ch}, 32'd0);
        chk("ms_last", {31'd0, out_last}, 32'd0);
        rst_l = 1'b1;
        repeat (5) cyc();
        chk("ms_noemit", {31'd0, out_valid}, 32'd0);

        // No strobes while disabled
        enable = 1'b0;
        for (int i = 0; i < 250; i++) begin
            cyc();
            if (sync === 1'b1) nsync++;
        end
        chk("dis_nosync", 32'(nsync), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
